// File: rtl/online_otf_converter.sv
// Online-to-binary converter: turns an MSD-first stream of radix-2^k signed
// digits into a two's-complement integer. It uses on-the-fly (Q/QM)
// conversion, so each digit is only appended and no wide adder is needed.
//
// Ports:
//   clk, rst    clock; synchronous active-high reset
//   din         signed digit, two's complement, MSD first
//   din_valid   din holds a digit
//   din_ready   converter accepts a digit this cycle
//   dout        converted result, W = no_of_digits*radix_log2+1 bits
//   dout_valid  dout holds a completed result
//   dout_ready  downstream takes dout
//   err         a digit of this result was -r (out of range); valid with dout_valid
module online_otf_converter #(
  parameter int unsigned no_of_digits = 4,
  parameter int unsigned radix_bits   = 4,
  parameter int unsigned radix_log2   = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [radix_bits-1:0]               din,
  input  logic                                din_valid,
  output logic                                din_ready,
  output logic [no_of_digits*radix_log2:0]    dout,
  output logic                                dout_valid,
  input  logic                                dout_ready,
  output logic                                err
);

  localparam int unsigned W  = no_of_digits * radix_log2 + 1;
  // Q/QM keep only the bits that can still be shifted out into a result
  localparam int unsigned WL = W - radix_log2;
  localparam int unsigned CW = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WL-1:0]         q_low;
  logic [WL-1:0]         qm_low;
  logic [CW-1:0]         cnt;
  logic                  sticky_err;

  logic                  accept;
  logic                  last_digit;
  logic                  release_c;
  logic                  d_neg;
  logic                  d_pos;
  logic                  d_bad;
  logic [radix_log2-1:0] dl;
  logic [radix_log2-1:0] dl_m1;
  logic [W-1:0]          q_nxt;

  // Digit decode
  assign dl         = din[radix_log2-1:0];
  assign dl_m1      = dl - radix_log2'(1);
  assign d_neg      = din[radix_bits-1];
  assign d_pos      = ~d_neg & (|dl);
  assign d_bad      = d_neg & ~(|dl);
  assign accept     = din_valid & din_ready;
  assign last_digit = (cnt == CW'(no_of_digits - 1));
  assign release_c  = dout_valid & dout_ready;

  // Append the digit to whichever of Q/QM avoids a borrow
  assign q_nxt = d_neg ? {qm_low, dl} : {q_low, dl};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept && last_digit) state_nxt = HOLD;
      HOLD:    if (dout_ready)           state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Output decode; ready is forced low while reset is held
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    case (state)
      COLLECT: din_ready  = ~rst;
      HOLD:    dout_valid = 1'b1;
      default: ;
    endcase
  end

  // Q/QM datapath, digit counter, result and error capture
  always_ff @(posedge clk) begin
    if (rst) begin
      q_low      <= '0;
      qm_low     <= '1;
      cnt        <= '0;
      sticky_err <= 1'b0;
      dout       <= '0;
      err        <= 1'b0;
    end else if (accept) begin
      q_low  <= q_nxt[WL-1:0];
      qm_low <= d_pos ? {q_low[WL-radix_log2-1:0], dl_m1}
                      : {qm_low[WL-radix_log2-1:0], dl_m1};
      sticky_err <= sticky_err | d_bad;
      if (last_digit) begin
        dout <= q_nxt;
        err  <= sticky_err | d_bad;
        cnt  <= cnt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (release_c) begin
      q_low      <= '0;
      qm_low     <= '1;
      cnt        <= '0;
      sticky_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_online_otf_converter.sv
// Self-checking bench for online_otf_converter (r=8, n=4, W=13).
// Expected results are queued when the last digit of a number is accepted
// and compared when the DUT hands the result downstream.
module tb_online_otf_converter;

  localparam int unsigned N  = 4;
  localparam int unsigned K  = 3;
  localparam int unsigned RB = 4;
  localparam int unsigned W  = N * K + 1;

  typedef struct packed {
    logic [W-1:0] val;
    logic         err;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [RB-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          err;

  exp_t exp_q[$];
  int   n_tests;
  int   n_fail;

  online_otf_converter #(
    .no_of_digits(N),
    .radix_bits  (RB),
    .radix_log2  (K)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference value: sum of d_i * 8^(n-1-i), reduced to W bits
  function automatic exp_t model(input logic [N*RB-1:0] digs);
    exp_t e;
    int   v;
    logic signed [RB-1:0] sd;
    v = 0;
    e.err = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      sd = digs[(N-1-i)*RB +: RB];
      v  = v * 8 + int'(sd);
      if (sd == -8) e.err = 1'b1;
    end
    e.val = W'(v);
    return e;
  endfunction

  // Drive cnt digits (MSD first); optionally queue the expected result
  task automatic send_digits(input logic [N*RB-1:0] digs, input int cnt,
                             input bit push, input exp_t e);
    logic rdy;
    int   t;
    for (int i = 0; i < cnt; i++) begin
      t = 0;
      forever begin
        @(negedge clk);
        din       = digs[(N-1-i)*RB +: RB];
        din_valid = 1'b1;
        rdy       = din_ready;
        @(posedge clk);
        if (rdy) break;
        t++;
        if (t > 200) begin
          check_eq("accept_timeout", 32'(t), 32'(0));
          din_valid = 1'b0;
          return;
        end
      end
    end
    if (push) begin
      exp_q.push_back(e);
      #1;
      check_eq("latency_valid", 32'(dout_valid), 32'(1));
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic send_num(input logic [N*RB-1:0] digs, input logic [W-1:0] ev, input logic ee);
    exp_t e;
    e.val = ev;
    e.err = ee;
    send_digits(digs, N, 1'b1, e);
  endtask

  // Scoreboard: compare whenever a result is handed downstream
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("dout", 32'(dout), 32'(e.val));
        check_eq("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    exp_t e;
    logic [N*RB-1:0] digs;
    bit   done;
    int   t;

    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_din_ready", 32'(din_ready), 32'(0));
    check_eq("rst_dout_valid", 32'(dout_valid), 32'(0));
    check_eq("rst_dout", 32'(dout), 32'(0));
    check_eq("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_din_ready", 32'(din_ready), 32'(1));

    // Directed values
    send_num(16'h1234, 13'h029C, 1'b0);
    send_num(16'h1F09, 13'h01B9, 1'b0);
    send_num(16'h000F, 13'h1FFF, 1'b0);
    send_num(16'h9999, 13'h1001, 1'b0);
    send_num(16'h7777, 13'h0FFF, 1'b0);

    // Backpressure with the next number waiting
    @(posedge clk); #2;
    dout_ready = 1'b0;
    send_num(16'h1234, 13'h029C, 1'b0);
    fork
      send_num(16'h0005, 13'h0005, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("bp_din_ready", 32'(din_ready), 32'(0));
          check_eq("bp_dout_valid", 32'(dout_valid), 32'(1));
          check_eq("bp_dout_stable", 32'(dout), 32'(13'h029C));
        end
        @(posedge clk); #2;
        dout_ready = 1'b1;
      end
    join

    // Out-of-range digit sets err; next clean number clears it
    send_num(16'h8001, 13'h1001, 1'b1);
    send_num(16'h0123, 13'h0053, 1'b0);

    // Reset mid-number discards partial digits
    e.val = '0;
    e.err = 1'b0;
    send_digits(16'h3300, 2, 1'b0, e);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_din_ready", 32'(din_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    send_num(16'h0010, 13'h0008, 1'b0);

    // Random legal digits with random backpressure
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          for (int i = 0; i < int'(N); i++)
            digs[i*RB +: RB] = RB'($urandom_range(0, 14) - 7);
          send_digits(digs, N, 1'b1, model(digs));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          dout_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #2;
    dout_ready = 1'b1;

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
